alu_nibble_sequencer: RTL and testbench

ALU_NIBBLE_SEQUENCER -- requirements
Module: alu_nibble_sequencer

---
 rtl/alu_seq_pkg.sv | 12 +
 rtl/dm74ls283_quad_adder.sv | 25 ++
 rtl/alu_nibble_sequencer.sv | 128 ++++++++++++
 tb/tb_alu_nibble_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the nibble-serial ALU sequencer.
package alu_seq_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/dm74ls283_quad_adder.sv
// Gate-level 4-bit ripple adder modelled on the 74LS283 (sum and carry only).
module dm74ls283_quad_adder
   import alu_seq_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             cin,
   output logic [NIB_W-1:0] sum,
   output logic             cout
);

   logic [NIB_W:0] c;

   assign c[0] = cin;

   generate
      for (genvar gi = 0; gi < NIB_W; gi++) begin : g_bit
         assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
         assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
      end
   endgenerate

   assign cout = c[NIB_W];

endmodule

// File: rtl/alu_nibble_sequencer.sv
// Nibble-serial add/subtract: one 4-bit adder reused for NIBBLES cycles per operation.
// Optional zero/ovf flag outputs are compiled in with ALU_FLAGS_EN.
module alu_nibble_sequencer
   import alu_seq_pkg::*;
#(
   parameter  int NIBBLES = 2,
   localparam int W       = NIB_W * NIBBLES
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         sub,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic         cout
`ifdef ALU_FLAGS_EN
   ,
   output logic         zero,
   output logic         ovf
`endif
);

   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_t           state_reg, state_next;
   logic [IDX_W-1:0] idx_reg;
   logic             carry_reg;
   logic [W-1:0]     a_reg, b_reg;
   logic [W-1:0]     result_reg, result_upd;
   logic             cout_reg;
   logic             accept, step, last;

   logic [NIB_W-1:0] nib_a, nib_b, nib_sum;
   logic             nib_cout;

   assign nib_a = a_reg[NIB_W*idx_reg +: NIB_W];
   assign nib_b = b_reg[NIB_W*idx_reg +: NIB_W];
   assign last  = (idx_reg == LAST_IDX);

   dm74ls283_quad_adder u_adder (
      .a    (nib_a),
      .b    (nib_b),
      .cin  (carry_reg),
      .sum  (nib_sum),
      .cout (nib_cout)
   );

   // Only the nibble selected by idx takes the new sum; the rest keep their value.
   generate
      for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
         assign result_upd[gi*NIB_W +: NIB_W] =
            (idx_reg == IDX_W'(gi)) ? nib_sum : result_reg[gi*NIB_W +: NIB_W];
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      step       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (last) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         idx_reg    <= '0;
         carry_reg  <= 1'b0;
         a_reg      <= '0;
         b_reg      <= '0;
         result_reg <= '0;
         cout_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            a_reg     <= a;
            b_reg     <= b ^ {W{sub}};
            carry_reg <= sub;
            idx_reg   <= '0;
         end else if (step) begin
            result_reg <= result_upd;
            carry_reg  <= nib_cout;
            idx_reg    <= idx_reg + 1'b1;
            if (last) cout_reg <= nib_cout;
         end
      end
   end

`ifdef ALU_FLAGS_EN
   logic zero_reg, ovf_reg;

   // Carry into the top bit is recovered from its sum bit: c_in = a ^ b ^ s.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         zero_reg <= 1'b0;
         ovf_reg  <= 1'b0;
      end else if (step && last) begin
         zero_reg <= (result_upd == '0);
         ovf_reg  <= nib_a[NIB_W-1] ^ nib_b[NIB_W-1] ^ nib_sum[NIB_W-1] ^ nib_cout;
      end
   end

   assign zero = zero_reg;
   assign ovf  = ovf_reg;
`endif

   assign busy   = (state_reg != IDLE);
   assign done   = (state_reg == DONE);
   assign result = result_reg;
   assign cout   = cout_reg;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed bench for alu_nibble_sequencer at NIBBLES=2 and NIBBLES=1.
`timescale 1ns/1ps
module tb_alu_nibble_sequencer;

   logic       clk;
   logic       rst_n;

   logic       start2, sub2;
   logic [7:0] a2, b2;
   logic       busy2, done2, cout2;
   logic [7:0] result2;

   logic       start1, sub1;
   logic [3:0] a1, b1;
   logic       busy1, done1, cout1;
   logic [3:0] result1;

`ifdef ALU_FLAGS_EN
   logic       zero2, ovf2, zero1, ovf1;
`endif

   int pass_cnt  = 0;
   int check_cnt = 0;

   alu_nibble_sequencer #(.NIBBLES(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2), .a(a2), .b(b2),
      .busy(busy2), .done(done2), .result(result2), .cout(cout2)
`ifdef ALU_FLAGS_EN
      , .zero(zero2), .ovf(ovf2)
`endif
   );

   alu_nibble_sequencer #(.NIBBLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .result(result1), .cout(cout1)
`ifdef ALU_FLAGS_EN
      , .zero(zero1), .ovf(ovf1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Issue one op on the 2-nibble DUT; lat = edges after acceptance until done seen.
   task automatic op2(input logic [7:0] ai, input logic [7:0] bi, input logic si, output int lat);
      start2 = 1'b1; a2 = ai; b2 = bi; sub2 = si;
      @(posedge clk); #1;
      start2 = 1'b0;
      lat = 0;
      while (!done2 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      $display("op2 a=%h b=%h sub=%0d -> result=%h cout=%0d lat=%0d", ai, bi, si, result2, cout2, lat);
   endtask

   task automatic op1(input logic [3:0] ai, input logic [3:0] bi, input logic si, output int lat);
      start1 = 1'b1; a1 = ai; b1 = bi; sub1 = si;
      @(posedge clk); #1;
      start1 = 1'b0;
      lat = 0;
      while (!done1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      $display("op1 a=%h b=%h sub=%0d -> result=%h cout=%0d lat=%0d", ai, bi, si, result1, cout1, lat);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start2 = 1'b0; sub2 = 1'b0; a2 = '0; b2 = '0;
      start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_cnt++; if (busy2 !== 1'b0) $display("FAIL reset_busy2 got %b want 0", busy2); else pass_cnt++;
      check_cnt++; if (done2 !== 1'b0) $display("FAIL reset_done2 got %b want 0", done2); else pass_cnt++;
      check_cnt++; if (result2 !== 8'h00) $display("FAIL reset_result2 got %h want 00", result2); else pass_cnt++;
      check_cnt++; if (cout2 !== 1'b0) $display("FAIL reset_cout2 got %b want 0", cout2); else pass_cnt++;
      check_cnt++; if (busy1 !== 1'b0 || result1 !== 4'h0) $display("FAIL reset_dut1 busy=%b result=%h want 0/0", busy1, result1); else pass_cnt++;
`ifdef ALU_FLAGS_EN
      check_cnt++; if (zero2 !== 1'b0 || ovf2 !== 1'b0) $display("FAIL reset_flags2 zero=%b ovf=%b want 0/0", zero2, ovf2); else pass_cnt++;
`endif
      $display("reset: busy2=%b done2=%b result2=%h cout2=%b", busy2, done2, result2, cout2);
   endtask

   task automatic test_add_overflow();
      int lat;
      op2(8'h7F, 8'h01, 1'b0, lat);
      check_cnt++; if (lat !== 2) $display("FAIL add7f_latency got %0d want 2", lat); else pass_cnt++;
      check_cnt++; if (result2 !== 8'h80) $display("FAIL add7f_result got %h want 80", result2); else pass_cnt++;
      check_cnt++; if (cout2 !== 1'b0) $display("FAIL add7f_cout got %b want 0", cout2); else pass_cnt++;
`ifdef ALU_FLAGS_EN
      check_cnt++; if (zero2 !== 1'b0 || ovf2 !== 1'b1) $display("FAIL add7f_flags zero=%b ovf=%b want 0/1", zero2, ovf2); else pass_cnt++;
`endif
      @(posedge clk); #1;
      check_cnt++; if (done2 !== 1'b0 || busy2 !== 1'b0) $display("FAIL add7f_after_done done=%b busy=%b want 0/0", done2, busy2); else pass_cnt++;
      repeat (3) @(posedge clk);
      #1;
      check_cnt++; if (result2 !== 8'h80 || busy2 !== 1'b0) $display("FAIL idle_hold result=%h busy=%b want 80/0", result2, busy2); else pass_cnt++;
   endtask

   task automatic test_add_wrap();
      int lat;
      op2(8'hFF, 8'h01, 1'b0, lat);
      check_cnt++; if (result2 !== 8'h00) $display("FAIL addff_result got %h want 00", result2); else pass_cnt++;
      check_cnt++; if (cout2 !== 1'b1) $display("FAIL addff_cout got %b want 1", cout2); else pass_cnt++;
`ifdef ALU_FLAGS_EN
      check_cnt++; if (zero2 !== 1'b1 || ovf2 !== 1'b0) $display("FAIL addff_flags zero=%b ovf=%b want 1/0", zero2, ovf2); else pass_cnt++;
`endif
      @(posedge clk); #1;
   endtask

   task automatic test_sub();
      int lat;
      op2(8'h05, 8'h07, 1'b1, lat);
      check_cnt++; if (result2 !== 8'hFE) $display("FAIL sub05_07_result got %h want fe", result2); else pass_cnt++;
      check_cnt++; if (cout2 !== 1'b0) $display("FAIL sub05_07_cout got %b want 0", cout2); else pass_cnt++;
`ifdef ALU_FLAGS_EN
      check_cnt++; if (zero2 !== 1'b0 || ovf2 !== 1'b0) $display("FAIL sub05_07_flags zero=%b ovf=%b want 0/0", zero2, ovf2); else pass_cnt++;
`endif
      @(posedge clk); #1;
      op2(8'h07, 8'h05, 1'b1, lat);
      check_cnt++; if (result2 !== 8'h02) $display("FAIL sub07_05_result got %h want 02", result2); else pass_cnt++;
      check_cnt++; if (cout2 !== 1'b1) $display("FAIL sub07_05_cout got %b want 1", cout2); else pass_cnt++;
      check_cnt++; if (lat !== 2) $display("FAIL sub07_05_latency got %0d want 2", lat); else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int ndone = 0;
      int prev  = -1;
      start2 = 1'b1; sub2 = 1'b0; a2 = 8'h10; b2 = 8'h20;
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk); #1;
         if (done2) begin
            ndone++;
            $display("b2b cycle=%0d done result=%h cout=%b", i, result2, cout2);
            check_cnt++; if (result2 !== 8'h30 || cout2 !== 1'b0) $display("FAIL b2b_result cycle %0d got %h/%b want 30/0", i, result2, cout2); else pass_cnt++;
            if (prev >= 0) begin
               check_cnt++; if (i - prev !== 4) $display("FAIL b2b_period got %0d want 4", i - prev); else pass_cnt++;
            end
            prev = i;
         end
         // Garbage operands whenever not idle: they must not be sampled.
         if (!busy2) begin a2 = 8'h10; b2 = 8'h20; end
         else begin a2 = 8'hEE; b2 = 8'h77; end
      end
      start2 = 1'b0;
      check_cnt++; if (ndone !== 4) $display("FAIL b2b_done_count got %0d want 4", ndone); else pass_cnt++;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_abort();
      int lat;
      int ndone = 0;
      start2 = 1'b1; sub2 = 1'b0; a2 = 8'h12; b2 = 8'h34;
      @(posedge clk); #1;
      start2 = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      $display("abort: busy2=%b done2=%b result2=%h cout2=%b", busy2, done2, result2, cout2);
      check_cnt++; if (busy2 !== 1'b0 || done2 !== 1'b0) $display("FAIL abort_state busy=%b done=%b want 0/0", busy2, done2); else pass_cnt++;
      check_cnt++; if (result2 !== 8'h00 || cout2 !== 1'b0) $display("FAIL abort_outputs result=%h cout=%b want 00/0", result2, cout2); else pass_cnt++;
      for (int i = 0; i < 5; i++) begin
         if (done2) ndone++;
         @(posedge clk); #1;
      end
      check_cnt++; if (ndone !== 0) $display("FAIL abort_no_done got %0d dones want 0", ndone); else pass_cnt++;
      op2(8'hAA, 8'h55, 1'b0, lat);
      check_cnt++; if (result2 !== 8'hFF || cout2 !== 1'b0) $display("FAIL postreset_add result=%h cout=%b want ff/0", result2, cout2); else pass_cnt++;
      check_cnt++; if (lat !== 2) $display("FAIL postreset_latency got %0d want 2", lat); else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_nibbles1();
      int lat;
      op1(4'hF, 4'hF, 1'b0, lat);
      check_cnt++; if (lat !== 1) $display("FAIL n1_latency got %0d want 1", lat); else pass_cnt++;
      check_cnt++; if (result1 !== 4'hE || cout1 !== 1'b1) $display("FAIL n1_add result=%h cout=%b want e/1", result1, cout1); else pass_cnt++;
`ifdef ALU_FLAGS_EN
      check_cnt++; if (zero1 !== 1'b0 || ovf1 !== 1'b0) $display("FAIL n1_add_flags zero=%b ovf=%b want 0/0", zero1, ovf1); else pass_cnt++;
`endif
      @(posedge clk); #1;
      check_cnt++; if (busy1 !== 1'b0 || done1 !== 1'b0) $display("FAIL n1_idle busy=%b done=%b want 0/0", busy1, done1); else pass_cnt++;
      op1(4'h3, 4'h5, 1'b1, lat);
      check_cnt++; if (result1 !== 4'hE || cout1 !== 1'b0) $display("FAIL n1_sub result=%h cout=%b want e/0", result1, cout1); else pass_cnt++;
      @(posedge clk); #1;
      op1(4'h7, 4'h1, 1'b0, lat);
      check_cnt++; if (result1 !== 4'h8 || cout1 !== 1'b0) $display("FAIL n1_add71 result=%h cout=%b want 8/0", result1, cout1); else pass_cnt++;
`ifdef ALU_FLAGS_EN
      check_cnt++; if (ovf1 !== 1'b1) $display("FAIL n1_ovf got %b want 1", ovf1); else pass_cnt++;
`endif
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_add_overflow();
      test_add_wrap();
      test_sub();
      test_back_to_back();
      test_reset_abort();
      test_nibbles1();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
